xy_frame_loader: RTL and testbench

Byte-stream loader that receives vector-display frames from a host link and writes X/Y point pairs into the frame RAM read by the display streamer. Parses a framed packet (sync, length, packed 9-bit X/Y points, checksum), emits one RAM write per point, and reports frame completion with length and checksum status. Sits between the host byte receiver (UART/SPI front end) and the X/Y frame RAM write port.

---
 rtl/xy_stream_pkg.sv | 21 ++
 rtl/xy_frame_loader.sv | 133 +++++++++++++
 tb/tb_xy_frame_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_stream_pkg.sv
// Shared constants and FSM state type for the X/Y frame path
// (loader and display streamer).
package xy_stream_pkg;

  localparam int unsigned DATA_WIDTH = 9;
  localparam int unsigned DEPTH      = 2387;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned ADDR_W     = $clog2(DEPTH);
  localparam int unsigned LEN_W      = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PT_B0,
    ST_PT_B1,
    ST_PT_B2,
    ST_CHK
  } state_t;

endpackage

// File: rtl/xy_frame_loader.sv
// Parses SYNC/LEN/points/CHK byte packets from the host link and emits one
// frame-RAM write per 9-bit X/Y point, plus frame done/ok and length-error pulses.
module xy_frame_loader
  import xy_stream_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_wr_en,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_x,
  output logic [DATA_WIDTH-1:0] o_wr_y,
  output logic                  o_frame_done,
  output logic                  o_frame_ok,
  output logic [LEN_W-1:0]      o_frame_len,
  output logic                  o_len_err
);

  state_t           state, state_next;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_inc;
  logic [7:0]       sum;
  logic [7:0]       b0, b1;
  logic [15:0]      len_field;
  logic             accept;
  logic             wr_fire, done_fire, len_err_fire;

  assign accept    = i_byte_valid & o_byte_ready;
  assign len_field = {len_hi, i_byte};
  assign idx_inc   = idx + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    wr_fire      = 1'b0;
    done_fire    = 1'b0;
    len_err_fire = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE:   if (i_byte == SYNC_BYTE) state_next = ST_LEN_HI;
        ST_LEN_HI: state_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (len_field == 16'd0 || len_field > 16'(DEPTH)) begin
            len_err_fire = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            state_next = ST_PT_B0;
          end
        end
        ST_PT_B0:  state_next = ST_PT_B1;
        ST_PT_B1:  state_next = ST_PT_B2;
        ST_PT_B2: begin
          wr_fire    = 1'b1;
          state_next = (idx_inc == len) ? ST_CHK : ST_PT_B0;
        end
        ST_CHK: begin
          done_fire  = 1'b1;
          state_next = ST_IDLE;
        end
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_byte_ready <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_x       <= '0;
      o_wr_y       <= '0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_frame_len  <= '0;
      o_len_err    <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      idx          <= '0;
      sum          <= '0;
      b0           <= '0;
      b1           <= '0;
    end else begin
      // Ready drops exactly in the cycle the done/error pulse is visible.
      o_byte_ready <= ~(done_fire | len_err_fire);
      o_wr_en      <= wr_fire;
      o_frame_done <= done_fire;
      o_len_err    <= len_err_fire;
      if (accept) begin
        unique case (state)
          ST_IDLE: sum <= '0;
          ST_LEN_HI: begin
            len_hi <= i_byte;
            sum    <= sum + i_byte;
          end
          ST_LEN_LO: begin
            len <= LEN_W'(len_field);
            idx <= '0;
            sum <= sum + i_byte;
          end
          ST_PT_B0: begin
            b0  <= i_byte;
            sum <= sum + i_byte;
          end
          ST_PT_B1: begin
            b1  <= i_byte;
            sum <= sum + i_byte;
          end
          ST_PT_B2: begin
            sum       <= sum + i_byte;
            idx       <= idx_inc;
            o_wr_addr <= ADDR_W'(idx);
            o_wr_x    <= {i_byte[0], b0};
            o_wr_y    <= {i_byte[1], b1};
          end
          ST_CHK: begin
            o_frame_ok  <= (i_byte == sum);
            o_frame_len <= len;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xy_frame_loader.sv
// Randomized bench for xy_frame_loader against a packet-level reference model
// of expected writes, frame-done results and length errors.
module tb_xy_frame_loader;
  import xy_stream_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_x, wr_y;
  logic                  frame_done, frame_ok;
  logic [LEN_W-1:0]      frame_len;
  logic                  len_err;

  xy_frame_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_byte      (in_byte),
    .i_byte_valid(in_valid),
    .o_byte_ready(byte_ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_x      (wr_x),
    .o_wr_y      (wr_y),
    .o_frame_done(frame_done),
    .o_frame_ok  (frame_ok),
    .o_frame_len (frame_len),
    .o_len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned addr; int unsigned x; int unsigned y; } wr_t;
  typedef struct { int unsigned ok; int unsigned len; } done_t;

  wr_t         exp_wr[$];
  done_t       exp_done[$];
  int unsigned px[$], py[$];
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned exp_len_err = 0, seen_len_err = 0, last_len = 0;
  bit          rand_valid = 1'b0;
  bit          junk_b2 = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got_it = 1'b0;
    bit acc;
    for (int i = 0; i < 200 && !got_it; i++) begin
      @(negedge clk);
      in_byte  = b;
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      acc      = in_valid && byte_ready;
      @(posedge clk);
      got_it = acc;
    end
    if (!got_it) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_points(input int unsigned n);
    px.delete();
    py.delete();
    for (int i = 0; i < int'(n); i++) begin
      px.push_back($urandom_range(0, 511));
      py.push_back($urandom_range(0, 511));
    end
  endtask

  // Sends the packet for px/py; n_send < N stops after that many points.
  task automatic send_packet(input bit bad_chk, input int unsigned n_send);
    int unsigned n = px.size();
    int unsigned s;
    logic [15:0] nn;
    logic [8:0]  x, y;
    logic [7:0]  b2;
    nn = 16'(n);
    s  = int'(nn[15:8]) + int'(nn[7:0]);
    send_byte(SYNC_BYTE);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int i = 0; i < int'(n_send); i++) begin
      x  = 9'(px[i]);
      y  = 9'(py[i]);
      b2 = {(junk_b2 ? 6'($urandom) : 6'd0), y[8], x[8]};
      exp_wr.push_back('{addr: i, x: px[i], y: py[i]});
      send_byte(x[7:0]);
      send_byte(y[7:0]);
      send_byte(b2);
      s = s + int'(x[7:0]) + int'(y[7:0]) + int'(b2);
    end
    if (n_send == n) begin
      exp_done.push_back('{ok: bad_chk ? 0 : 1, len: n});
      last_len = n;
      send_byte(8'((s + (bad_chk ? 1 : 0)) % 256));
    end
  endtask

  task automatic send_len_err(input logic [7:0] hi, input logic [7:0] lo);
    exp_len_err++;
    send_byte(SYNC_BYTE);
    send_byte(hi);
    send_byte(lo);
  endtask

  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    if (wr_en) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_x", wr_x, e.x);
        check("wr_y", wr_y, e.y);
      end
    end
    if (frame_done) begin
      check("done_ready_low", byte_ready, 0);
      check("done_no_write", wr_en, 0);
      if (exp_done.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = exp_done.pop_front();
        check("frame_ok", frame_ok, d.ok);
        check("frame_len", frame_len, d.len);
      end
    end
    if (len_err) begin
      seen_len_err++;
      check("lenerr_ready_low", byte_ready, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", byte_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_done", frame_done, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_len", frame_len, 0);
    check("rst_len_err", len_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", byte_ready, 1);

    // Known single-point packet, good then bad checksum
    px = '{9'h123};
    py = '{9'h045};
    send_packet(1'b0, 1);
    idle(4);
    send_packet(1'b1, 1);
    idle(4);

    // Illegal lengths 0 and DEPTH+1, then a normal packet
    send_len_err(8'h00, 8'h00);
    idle(3);
    send_len_err(8'h09, 8'h54);
    idle(3);
    check("len_err_count", seen_len_err, exp_len_err);
    gen_points(2);
    send_packet(1'b0, 2);
    idle(4);

    // Garbage prefix, throttled valid, SYNC value inside body
    rand_valid = 1'b1;
    junk_b2    = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    gen_points(3);
    px[0] = 9'h1A5;
    py[0] = 9'h0A5;
    send_packet(1'b0, 3);
    idle(4);

    for (int k = 0; k < 6; k++) begin
      gen_points($urandom_range(1, 8));
      send_packet(1'($urandom_range(0, 1)), px.size());
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(4);

    // Full-depth frame at one byte per cycle
    rand_valid = 1'b0;
    gen_points(DEPTH);
    send_packet(1'b0, DEPTH);
    idle(4);

    // Reset after 2 of 4 points
    gen_points(4);
    send_packet(1'b0, 2);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_ready", byte_ready, 0);
    check("midrst_wr_en", wr_en, 0);
    rst = 1'b0;
    idle(3);
    gen_points(3);
    send_packet(1'b0, 3);
    idle(6);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    check("len_err_total", seen_len_err, exp_len_err);
    check("frame_len_held", frame_len, last_len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
